// File: rtl/mdu_iter_if.sv
// ----------------------------------------------------------------------------
// mdu_iter_if
// Bundle between the EX-stage issue logic (master) and the iterative
// multiply/divide unit (slave).
//   flush     : exception flush, aborts any operation
//   stall     : downstream hold of EX; keeps a finished result presented
//   op_valid  : EX holds a MULT/MULTU/DIV/DIVU instruction
//   op_type   : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a     : rs operand / dividend
//   src_b     : rt operand / divisor
//   stall_req : pipeline hold request from the unit (combinational)
//   busy      : unit not idle
//   res_valid : HI/LO write enable
//   res_hi    : product high half or remainder
//   res_lo    : product low half or quotient
// ----------------------------------------------------------------------------
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             stall;
    logic             op_valid;
    logic [1:0]       op_type;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             stall_req;
    logic             busy;
    logic             res_valid;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    modport master (
        output flush, stall, op_valid, op_type, src_a, src_b,
        input  stall_req, busy, res_valid, res_hi, res_lo
    );

    modport slave (
        input  flush, stall, op_valid, op_type, src_a, src_b,
        output stall_req, busy, res_valid, res_hi, res_lo
    );
endinterface

// File: rtl/mdu_iter.sv
// ----------------------------------------------------------------------------
// mdu_iter
// Multi-cycle multiply/divide unit for the EX stage. Multiplies are computed
// in one shot and then held for MUL_LATENCY cycles; divides use a radix-2
// restoring loop, one quotient bit per cycle. While computing, the unit
// requests a pipeline stall; the result is then presented for one cycle (or
// longer while EX is held by stall). Flush aborts at any time.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mdu_iter_if slave modport (operands, control, results)
// ----------------------------------------------------------------------------
module mdu_iter #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    mdu_iter_if.slave   bus
);
    localparam int CW = $clog2((WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_res_valid;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_stall_req;
    logic               w_signed;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Stall request toward the pipeline controller; flush always drops it.
    always_comb begin
        w_stall_req = 1'b0;
        case (r_state)
            S_IDLE:  w_stall_req = bus.op_valid & ~bus.flush;
            S_MUL:   w_stall_req = ~bus.flush;
            S_DIV:   w_stall_req = ~bus.flush;
            S_DONE:  w_stall_req = 1'b0;
            default: w_stall_req = 1'b0;
        endcase
    end

    // Operand conditioning at acceptance: extended product and magnitudes.
    // MULT/DIV are the even op codes, so op_type[0]==0 means signed.
    always_comb begin
        w_signed = ~bus.op_type[0];
        if (w_signed) begin
            w_a_ext = {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a};
            w_b_ext = {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b};
        end else begin
            w_a_ext = {{WIDTH{1'b0}}, bus.src_a};
            w_b_ext = {{WIDTH{1'b0}}, bus.src_b};
        end
        // Truncating to 2*WIDTH gives the correct two's complement product.
        w_prod = w_a_ext * w_b_ext;
        if (w_signed && bus.src_a[WIDTH-1]) begin
            w_abs_a = {WIDTH{1'b0}} - bus.src_a;
        end else begin
            w_abs_a = bus.src_a;
        end
        if (w_signed && bus.src_b[WIDTH-1]) begin
            w_abs_b = {WIDTH{1'b0}} - bus.src_b;
        end else begin
            w_abs_b = bus.src_b;
        end
    end

    // One restoring-division step plus the sign fixup for the final step.
    // The dividend is shifted out of r_quo's MSB while quotient bits enter
    // its LSB. A set borrow bit in w_diff means the trial subtract failed.
    always_comb begin
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_dvs};
        if (!w_diff[WIDTH]) begin
            w_rem_nx = w_diff[WIDTH-1:0];
            w_quo_nx = {r_quo[WIDTH-2:0], 1'b1};
        end else begin
            w_rem_nx = w_shift[WIDTH-1:0];
            w_quo_nx = {r_quo[WIDTH-2:0], 1'b0};
        end
        if (r_neg_q) begin
            w_quo_fix = {WIDTH{1'b0}} - w_quo_nx;
        end else begin
            w_quo_fix = w_quo_nx;
        end
        if (r_neg_r) begin
            w_rem_fix = {WIDTH{1'b0}} - w_rem_nx;
        end else begin
            w_rem_fix = w_rem_nx;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_hi    <= '0;
            r_res_lo    <= '0;
            r_prod      <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else if (bus.flush) begin
            // Results are kept; only the handshake state is cleared.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        r_busy <= 1'b1;
                        if (!bus.op_type[1]) begin
                            r_prod  <= w_prod;
                            r_cnt   <= CW'(MUL_LATENCY - 1);
                            r_state <= S_MUL;
                        end else if (bus.src_b == {WIDTH{1'b0}}) begin
                            r_res_lo    <= {WIDTH{1'b1}};
                            r_res_hi    <= bus.src_a;
                            r_res_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_quo   <= w_abs_a;
                            r_dvs   <= w_abs_b;
                            r_rem   <= '0;
                            r_neg_q <= w_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                            r_neg_r <= w_signed & bus.src_a[WIDTH-1];
                            r_cnt   <= CW'(WIDTH - 1);
                            r_state <= S_DIV;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        r_res_hi    <= r_prod[2*WIDTH-1:WIDTH];
                        r_res_lo    <= r_prod[WIDTH-1:0];
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    if (r_cnt == '0) begin
                        r_res_hi    <= w_rem_fix;
                        r_res_lo    <= w_quo_fix;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    // While EX is held the same instruction is still there,
                    // so the result stays presented.
                    if (!bus.stall) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall_req = w_stall_req;
    assign bus.busy      = r_busy;
    assign bus.res_valid = r_res_valid;
    assign bus.res_hi    = r_res_hi;
    assign bus.res_lo    = r_res_lo;

endmodule
